// File: rtl/j_audio_pkg.sv
// Shared constants, state encoding and slot helpers for the I2S audio transmitter.
// Latency: n/a (package); backpressure: n/a.
package j_audio_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int FRAME_BITS   = 32;
    localparam int SLOT_W       = $clog2(FRAME_BITS);
    localparam int WS_RISE_SLOT = 15;
    localparam int WS_FALL_SLOT = 31;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;

    typedef logic [SLOT_W-1:0]     slot_t;
    typedef logic [FRAME_BITS-1:0] frame_t;

    // ws is raised one slot ahead of the right-channel MSB and dropped one slot ahead of the left MSB.
    function automatic logic ws_for_slot(input slot_t slot);
        return (slot >= slot_t'(WS_RISE_SLOT)) && (slot < slot_t'(WS_FALL_SLOT));
    endfunction

    function automatic logic last_slot(input slot_t slot);
        return slot == slot_t'(FRAME_BITS - 1);
    endfunction

endpackage

// File: rtl/j_i2s_clkdiv.sv
// I2S bit-clock divider: sck half-period is sclkdiv+1 clk, with one-clk rise/fall strobes.
// Latency: strobes are combinational on the clk that sck toggles; backpressure: none.
module j_i2s_clkdiv #(
    parameter int DIVW = 8
) (
    input  logic            clk,
    input  logic            resetl,
    input  logic            run,
    input  logic [DIVW-1:0] sclkdiv,
    output logic            sck,
    output logic            sck_rise,
    output logic            sck_fall
);

    logic [DIVW-1:0] divcnt_q, divcnt_d;
    logic            sck_q, sck_d;
    logic            hit;

    always_comb begin
        // >= so that lowering sclkdiv below the running count toggles at once instead of wrapping.
        hit      = run && (divcnt_q >= sclkdiv);
        sck_rise = hit && !sck_q;
        sck_fall = hit && sck_q;
        divcnt_d = divcnt_q;
        sck_d    = sck_q;
        if (!run) begin
            divcnt_d = '0;
            sck_d    = 1'b0;
        end else if (hit) begin
            divcnt_d = '0;
            sck_d    = !sck_q;
        end else begin
            divcnt_d = divcnt_q + DIVW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            divcnt_q <= '0;
            sck_q    <= 1'b0;
        end else begin
            divcnt_q <= divcnt_d;
            sck_q    <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/j_i2s_tx.sv
// I2S transmitter: holds DSP L/R samples, shifts a 32-slot frame MSB first, pulses frame_int per frame load.
// Latency: all outputs registered, frame starts one clk after i2s_en is seen; backpressure: none, holds resent if not rewritten.
module j_i2s_tx
    import j_audio_pkg::*;
#(
    parameter int DIVW = 8
) (
    input  logic                clk,
    input  logic                resetl,
    input  logic                i2s_en,
    input  logic                ltxw,
    input  logic                rtxw,
    input  logic [SAMPLE_W-1:0] dspd,
    input  logic [DIVW-1:0]     sclkdiv,
    output logic                sck,
    output logic                ws,
    output logic                sdo,
    output logic                frame_int,
    output logic                busy
);

    i2s_state_e          state_q, state_d;
    logic [SAMPLE_W-1:0] lhold_q, lhold_d;
    logic [SAMPLE_W-1:0] rhold_q, rhold_d;
    frame_t              shift_q, shift_d;
    slot_t               slot_q, slot_d;
    logic                sdo_q, sdo_d;
    logic                ws_q, ws_d;
    logic                frame_int_q, frame_int_d;
    logic                load_frame;
    logic                run;
    logic                sck_rise;
    logic                sck_fall;

    assign run = (state_q == RUN) && i2s_en;

    j_i2s_clkdiv #(
        .DIVW (DIVW)
    ) u_clkdiv (
        .clk      (clk),
        .resetl   (resetl),
        .run      (run),
        .sclkdiv  (sclkdiv),
        .sck      (sck),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    always_comb begin
        lhold_d     = ltxw ? dspd : lhold_q;
        rhold_d     = rtxw ? dspd : rhold_q;
        state_d     = state_q;
        shift_d     = shift_q;
        slot_d      = slot_q;
        sdo_d       = sdo_q;
        ws_d        = ws_q;
        frame_int_d = 1'b0;
        load_frame  = 1'b0;

        case (state_q)
            IDLE: begin
                sdo_d = 1'b0;
                ws_d  = 1'b0;
                if (i2s_en) begin
                    state_d    = RUN;
                    load_frame = 1'b1;
                end
            end
            RUN: begin
                if (!i2s_en) begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                    ws_d    = 1'b0;
                end else if (sck_fall) begin
                    if (last_slot(slot_q)) begin
                        load_frame = 1'b1;
                    end else begin
                        slot_d  = slot_q + slot_t'(1);
                        shift_d = shift_q << 1;
                        sdo_d   = shift_q[FRAME_BITS-2];
                        ws_d    = ws_for_slot(slot_q + slot_t'(1));
                    end
                end
            end
        endcase

        // Uses the pre-write holds, so a strobe on this clk lands in the following frame.
        if (load_frame) begin
            shift_d     = {lhold_q, rhold_q};
            slot_d      = '0;
            sdo_d       = lhold_q[SAMPLE_W-1];
            ws_d        = ws_for_slot('0);
            frame_int_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            state_q     <= IDLE;
            lhold_q     <= '0;
            rhold_q     <= '0;
            shift_q     <= '0;
            slot_q      <= '0;
            sdo_q       <= 1'b0;
            ws_q        <= 1'b0;
            frame_int_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lhold_q     <= lhold_d;
            rhold_q     <= rhold_d;
            shift_q     <= shift_d;
            slot_q      <= slot_d;
            sdo_q       <= sdo_d;
            ws_q        <= ws_d;
            frame_int_q <= frame_int_d;
        end
    end

    assign sdo       = sdo_q;
    assign ws        = ws_q;
    assign frame_int = frame_int_q;
    assign busy      = (state_q == RUN);

    a_sck_edges_exclusive: assert property (@(posedge clk) disable iff (!resetl) !(sck_rise && sck_fall));

endmodule

// File: tb/tb_j_i2s_tx.sv
// Scoreboarded bench for j_i2s_tx: directed stimulus queues expected frames, a monitor rebuilds frames from sdo/ws.
module tb_j_i2s_tx;

    logic        clk = 1'b0;
    logic        resetl;
    logic        i2s_en;
    logic        ltxw;
    logic        rtxw;
    logic [15:0] dspd;
    logic [7:0]  sclkdiv;
    logic        sck;
    logic        ws;
    logic        sdo;
    logic        frame_int;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          period;
    } exp_t;

    exp_t exp_q[$];

    j_i2s_tx #(.DIVW(8)) dut (
        .clk       (clk),
        .resetl    (resetl),
        .i2s_en    (i2s_en),
        .ltxw      (ltxw),
        .rtxw      (rtxw),
        .dspd      (dspd),
        .sclkdiv   (sclkdiv),
        .sck       (sck),
        .ws        (ws),
        .sdo       (sdo),
        .frame_int (frame_int),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input int period);
        exp_t e;
        e.data   = data;
        e.period = period;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic l, input logic r, input logic [15:0] d);
        ltxw = l;
        rtxw = r;
        dspd = d;
        @(negedge clk);
        ltxw = 1'b0;
        rtxw = 1'b0;
    endtask

    task automatic wait_frame(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_int && n < bound);
        chk("frame_int_seen", {31'd0, frame_int}, 32'd1);
    endtask

    task automatic measure_half(input string name, input int exp_len);
        logic lvl;
        int   n;
        lvl = sck;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sck == lvl && n < 20);
        chk(name, n, exp_len);
    endtask

    // Monitor state: frames rebuilt from sdo/ws sampled at each sck rise (mid-slot).
    logic        mon_in_frame = 1'b0;
    logic        mon_done     = 1'b0;
    logic        mon_prev_sck = 1'b0;
    int          mon_nrise    = 0;
    int          mon_cyc      = 0;
    int          mon_pend     = 0;
    logic [31:0] mon_dbits    = '0;
    logic [31:0] mon_wbits    = '0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetl !== 1'b1 || busy !== 1'b1) begin
                mon_in_frame = 1'b0;
                mon_pend     = 0;
            end else if (frame_int) begin
                if (mon_pend != 0) chk("frame_period", mon_cyc, mon_pend);
                mon_pend     = 0;
                mon_in_frame = 1'b1;
                mon_done     = 1'b0;
                mon_nrise    = 0;
                mon_cyc      = 1;
                mon_dbits    = '0;
                mon_wbits    = '0;
            end else if (mon_in_frame) begin
                mon_cyc++;
                if (!mon_done && sck && !mon_prev_sck) begin
                    mon_dbits = {mon_dbits[30:0], sdo};
                    mon_wbits = {mon_wbits[30:0], ws};
                    mon_nrise++;
                    if (mon_nrise == 32) begin
                        mon_done = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got %h expected none", mon_dbits);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_data", mon_dbits, e.data);
                            chk("ws_pattern", mon_wbits, 32'h0001FFFE);
                            mon_pend = e.period;
                        end
                    end
                end
            end
            mon_prev_sck = sck;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin : stimulus
        resetl  = 1'b0;
        i2s_en  = 1'b1;
        ltxw    = 1'b0;
        rtxw    = 1'b0;
        dspd    = '0;
        sclkdiv = 8'd1;

        // Reset dominates a held enable.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", {27'd0, sck, ws, sdo, frame_int, busy}, 32'd0);
        end
        resetl = 1'b1;
        @(negedge clk);
        chk("first_frame_int", {30'd0, frame_int, busy}, 32'd3);
        i2s_en = 1'b0;
        @(negedge clk);
        chk("disable_after_reset", {30'd0, frame_int, busy}, 32'd0);

        // Basic frame, then a write colliding with the second frame's load.
        wr(1'b1, 1'b0, 16'hA55A);
        wr(1'b0, 1'b1, 16'h0F0F);
        push_exp(32'hA55A0F0F, 128);
        push_exp(32'hA55A0F0F, 128);
        push_exp(32'h12340F0F, 128);
        i2s_en = 1'b1;
        wait_frame(10);
        @(negedge clk);
        chk("frame_int_one_clk", {31'd0, frame_int}, 32'd0);
        repeat (126) @(negedge clk);
        ltxw = 1'b1;
        dspd = 16'h1234;
        @(negedge clk);
        ltxw = 1'b0;
        chk("collision_on_load", {31'd0, frame_int}, 32'd1);

        // Fastest divider from frame 4, then a slower divider mid frame 6.
        wait_frame(200);
        push_exp(32'h12340F0F, 64);
        push_exp(32'h12340F0F, 64);
        push_exp(32'h12340F0F, 0);
        wait_frame(200);
        sclkdiv = 8'd0;
        wait_frame(100);
        wait_frame(100);
        repeat (10) @(negedge clk);
        sclkdiv = 8'd3;
        measure_half("sck_first_edge", 4);
        for (int i = 0; i < 4; i++) measure_half("sck_half_period", 4);

        // Disable in slot 20 of frame 7 (8 clk per slot).
        wait_frame(400);
        repeat (164) @(negedge clk);
        chk("ws_slot20", {30'd0, ws, busy}, 32'd3);
        i2s_en = 1'b0;
        @(negedge clk);
        chk("disable_outputs", {28'd0, sck, ws, sdo, busy}, 32'd0);

        // Re-enable with a new left sample; slot 0 carries its MSB.
        wr(1'b1, 1'b0, 16'h8001);
        push_exp(32'h80010F0F, 256);
        i2s_en = 1'b1;
        @(negedge clk);
        chk("reenable_slot0", {28'd0, frame_int, busy, sdo, ws}, 32'hE);

        // Both strobes together load both holds.
        repeat (40) @(negedge clk);
        wr(1'b1, 1'b1, 16'hFFFF);
        push_exp(32'hFFFFFFFF, 0);
        wait_frame(400);
        wait_frame(400);
        i2s_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("idle_outputs", {27'd0, sck, ws, sdo, frame_int, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
